// File: rtl/csa_acc_pipe.sv
// Two-stage carry-save compressor: stage 1 reduces the operands and carry-in to a sum/carry pair,
// stage 2 either emits that pair or folds it into a carry-save accumulator via a 4:2 merge.
module csa_acc_pipe #(
    parameter int WIDTH     = 32,
    parameter int NUM_OPS   = 4,
    parameter int ACC_WIDTH = 40,
    parameter int SIGNED    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_OPS*WIDTH-1:0]   in_ops,
    input  logic                       in_ci,
    input  logic                       in_acc,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_WIDTH-1:0]       out_sum,
    output logic [ACC_WIDTH-1:0]       out_carry,
    output logic [ACC_WIDTH-1:0]       out_res,
    output logic                       acc_pending
);

    function automatic logic [ACC_WIDTH-1:0] extend(input logic [WIDTH-1:0] op);
        logic fill;
        fill = (SIGNED != 0) ? op[WIDTH-1] : 1'b0;
        return {{(ACC_WIDTH-WIDTH){fill}}, op};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] csa_sum(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] b,
                                                     input logic [ACC_WIDTH-1:0] c);
        return a ^ b ^ c;
    endfunction

    // Majority shifted up one place; the carry out of the top bit is dropped (mod 2^ACC_WIDTH).
    function automatic logic [ACC_WIDTH-1:0] csa_carry(input logic [ACC_WIDTH-1:0] a,
                                                       input logic [ACC_WIDTH-1:0] b,
                                                       input logic [ACC_WIDTH-1:0] c);
        logic [ACC_WIDTH-1:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[ACC_WIDTH-2:0], 1'b0};
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [ACC_WIDTH-1:0] s1_sum_q, s1_sum_d;
    logic [ACC_WIDTH-1:0] s1_carry_q, s1_carry_d;
    logic                 s1_acc_q, s1_acc_d;
    logic                 s1_last_q, s1_last_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic [ACC_WIDTH-1:0] out_carry_q, out_carry_d;
    logic [ACC_WIDTH-1:0] out_res_q, out_res_d;
    logic [ACC_WIDTH-1:0] acc_s_q, acc_s_d;
    logic [ACC_WIDTH-1:0] acc_c_q, acc_c_d;
    logic                 acc_pending_q, acc_pending_d;

    logic                 s2_take;
    logic                 accept;
    logic                 emit;
    logic [ACC_WIDTH-1:0] ops_ext [NUM_OPS+1];
    logic [ACC_WIDTH-1:0] red_sum, red_carry, red_tmp;
    logic [ACC_WIDTH-1:0] m1_s, m1_c, m2_s, m2_c;
    logic [ACC_WIDTH-1:0] emit_sum, emit_carry;

    assign s2_take  = s1_valid_q && !(out_valid_q && !out_ready);
    assign in_ready = !s1_valid_q || s2_take;
    assign accept   = in_valid && in_ready;
    assign emit     = s2_take && (!s1_acc_q || s1_last_q);

    // Extend operands; carry-in rides as the final addend of the 3:2 chain.
    always_comb begin
        for (int k = 0; k < NUM_OPS; k++) begin
            ops_ext[k] = extend(in_ops[k*WIDTH +: WIDTH]);
        end
        ops_ext[NUM_OPS] = {{(ACC_WIDTH-1){1'b0}}, in_ci};
    end

    // Linear 3:2 reduction chain of all operands plus carry-in.
    always_comb begin
        red_sum   = ops_ext[0];
        red_carry = ops_ext[1];
        red_tmp   = '0;
        for (int k = 2; k <= NUM_OPS; k++) begin
            red_tmp   = csa_sum(red_sum, red_carry, ops_ext[k]);
            red_carry = csa_carry(red_sum, red_carry, ops_ext[k]);
            red_sum   = red_tmp;
        end
    end

    // Stage-1 register next state.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_carry_d = s1_carry_q;
        s1_acc_d   = s1_acc_q;
        s1_last_d  = s1_last_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_sum_d   = red_sum;
            s1_carry_d = red_carry;
            s1_acc_d   = in_acc;
            s1_last_d  = in_last;
        end else if (s2_take) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // 4:2 merge of the accumulator pair with the stage-1 pair.
    always_comb begin
        m1_s = csa_sum(acc_s_q, acc_c_q, s1_sum_q);
        m1_c = csa_carry(acc_s_q, acc_c_q, s1_sum_q);
        m2_s = csa_sum(m1_s, m1_c, s1_carry_q);
        m2_c = csa_carry(m1_s, m1_c, s1_carry_q);
        if (s1_acc_q) begin
            emit_sum   = m2_s;
            emit_carry = m2_c;
        end else begin
            emit_sum   = s1_sum_q;
            emit_carry = s1_carry_q;
        end
    end

    // Stage-2 output and accumulator next state.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_sum_d     = out_sum_q;
        out_carry_d   = out_carry_q;
        out_res_d     = out_res_q;
        acc_s_d       = acc_s_q;
        acc_c_d       = acc_c_q;
        acc_pending_d = acc_pending_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_sum_d   = emit_sum;
            out_carry_d = emit_carry;
            out_res_d   = emit_sum + emit_carry;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (s2_take && s1_acc_q) begin
            if (s1_last_q) begin
                acc_s_d       = '0;
                acc_c_d       = '0;
                acc_pending_d = 1'b0;
            end else begin
                acc_s_d       = m2_s;
                acc_c_d       = m2_c;
                acc_pending_d = 1'b1;
            end
        end else begin
            acc_pending_d = acc_pending_q;
        end
    end

    // All pipeline state; synchronous active-low reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sum_q      <= '0;
            s1_carry_q    <= '0;
            s1_acc_q      <= 1'b0;
            s1_last_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sum_q     <= '0;
            out_carry_q   <= '0;
            out_res_q     <= '0;
            acc_s_q       <= '0;
            acc_c_q       <= '0;
            acc_pending_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sum_q      <= s1_sum_d;
            s1_carry_q    <= s1_carry_d;
            s1_acc_q      <= s1_acc_d;
            s1_last_q     <= s1_last_d;
            out_valid_q   <= out_valid_d;
            out_sum_q     <= out_sum_d;
            out_carry_q   <= out_carry_d;
            out_res_q     <= out_res_d;
            acc_s_q       <= acc_s_d;
            acc_c_q       <= acc_c_d;
            acc_pending_q <= acc_pending_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_sum     = out_sum_q;
    assign out_carry   = out_carry_q;
    assign out_res     = out_res_q;
    assign acc_pending = acc_pending_q;

endmodule

// File: tb/tb_csa_acc_pipe.sv
// Directed bench for csa_acc_pipe: unsigned and signed instances share one stimulus stream.
module tb_csa_acc_pipe;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int AW = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready, u1_in_ready;
    logic [N*W-1:0] in_ops;
    logic          in_ci, in_acc, in_last;
    logic          out_valid, u1_out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum, out_carry, out_res;
    logic [AW-1:0] u1_out_sum, u1_out_carry, u1_out_res;
    logic          acc_pending, u1_acc_pending;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    csa_acc_pipe #(.WIDTH(W), .NUM_OPS(N), .ACC_WIDTH(AW), .SIGNED(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ops(in_ops), .in_ci(in_ci), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_carry(out_carry), .out_res(out_res), .acc_pending(acc_pending)
    );

    csa_acc_pipe #(.WIDTH(W), .NUM_OPS(N), .ACC_WIDTH(AW), .SIGNED(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u1_in_ready),
        .in_ops(in_ops), .in_ci(in_ci), .in_acc(in_acc), .in_last(in_last),
        .out_valid(u1_out_valid), .out_ready(out_ready), .out_sum(u1_out_sum),
        .out_carry(u1_out_carry), .out_res(u1_out_res), .acc_pending(u1_acc_pending)
    );

    typedef struct {
        logic [W-1:0]  op0, op1, op2, op3;
        logic          ci;
        logic [AW-1:0] exp_u;
        logic [AW-1:0] exp_s;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d,
                             input logic ci, input logic acc, input logic last);
        logic ok;
        ok       = 1'b0;
        in_ops   = {d, c, b, a};
        in_ci    = ci;
        in_acc   = acc;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                cyc();
                break;
            end
            cyc();
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    logic [AW-1:0] sc;
    logic [AW-1:0] got [$];
    logic          stable;
    int            beat;

    initial begin
        vecs[0] = '{32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 40'd11, 40'd11};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 40'h01_FFFF_FFFF, 40'hFF_FFFF_FFFF};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                    40'h03_FFFF_FFFD, 40'hFF_FFFF_FFFD};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0,
                    40'h02_0000_0000, 40'hFE_0000_0000};
        vecs[4] = '{32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 40'd1, 40'd1};
        vecs[5] = '{32'h1234_5678, 32'h1111_1111, 32'd0, 32'h0101_0101, 1'b0,
                    40'h00_2446_688A, 40'h00_2446_688A};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ops    = '0;
        in_ci     = 1'b0;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        do_reset();
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_in_ready", in_ready, 64'd1);
        chk("rst_acc_pending", acc_pending, 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_out_carry", out_carry, 64'd0);
        chk("rst_out_res", out_res, 64'd0);

        for (int i = 0; i < 6; i++) begin
            send_beat(vecs[i].op0, vecs[i].op1, vecs[i].op2, vecs[i].op3, vecs[i].ci, 1'b0, 1'b0);
            chk($sformatf("vec%0d_lat1", i), out_valid, 64'd0);
            cyc();
            chk($sformatf("vec%0d_valid", i), out_valid, 64'd1);
            chk($sformatf("vec%0d_res", i), out_res, vecs[i].exp_u);
            sc = out_sum + out_carry;
            chk($sformatf("vec%0d_pair", i), sc, vecs[i].exp_u);
            chk($sformatf("vec%0d_signed_res", i), u1_out_res, vecs[i].exp_s);
            cyc();
            chk($sformatf("vec%0d_drain", i), out_valid, 64'd0);
        end

        // Three-beat group of all-ones operands.
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        chk("grp_pending1", acc_pending, 64'd1);
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
        chk("grp_no_early_out", out_valid, 64'd0);
        cyc();
        chk("grp_valid", out_valid, 64'd1);
        chk("grp_res", out_res, 64'h0B_FFFF_FFF4);
        sc = out_sum + out_carry;
        chk("grp_pair", sc, 64'h0B_FFFF_FFF4);
        chk("grp_signed_res", u1_out_res, 64'hFF_FFFF_FFF4);
        chk("grp_pending0", acc_pending, 64'd0);
        cyc();

        // Single-beat group equals the stand-alone result.
        send_beat(32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 1'b1, 1'b1);
        cyc();
        chk("single_grp_res", out_res, 64'd11);
        chk("single_grp_pending", acc_pending, 64'd0);
        cyc();

        // Stand-alone beat inside an open group.
        send_beat(32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        send_beat(32'd7, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("mixed_sa_res", out_res, 64'd7);
        chk("mixed_pending", acc_pending, 64'd1);
        send_beat(32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        cyc();
        chk("mixed_grp_res", out_res, 64'd6);
        chk("mixed_grp_pending", acc_pending, 64'd0);
        cyc();

        // Backpressure: four streamed beats, consumer stalled for six cycles.
        beat   = 0;
        stable = 1'b1;
        got.delete();
        for (int c = 0; c < 30; c++) begin
            out_ready = (c >= 6);
            if (beat < 4) begin
                in_ops   = {32'd0, 32'd0, 32'd0, 32'((beat + 1) * 10)};
                in_ci    = 1'b0;
                in_acc   = 1'b0;
                in_last  = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 5) begin
                chk("bp_absorbed", beat, 64'd2);
                chk("bp_in_ready", in_ready, 64'd0);
                chk("bp_out_valid", out_valid, 64'd1);
            end
            if (!out_ready && out_valid && out_res != 40'd10) stable = 1'b0;
            if (out_valid && out_ready) got.push_back(out_res);
            if (in_valid && in_ready) beat++;
            cyc();
            if (got.size() == 4) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_stable", stable, 64'd1);
        chk("bp_count", got.size(), 64'd4);
        for (int k = 0; k < got.size(); k++) begin
            chk($sformatf("bp_order%0d", k), got[k], 64'((k + 1) * 10));
        end
        cyc();

        // Reset in the middle of an open group discards it.
        send_beat(32'd100, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        send_beat(32'd100, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        cyc();
        chk("midrst_pending_before", acc_pending, 64'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_pending_after", acc_pending, 64'd0);
        chk("midrst_out_valid", out_valid, 64'd0);
        send_beat(32'd3, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        cyc();
        chk("midrst_close_valid", out_valid, 64'd1);
        chk("midrst_close_res", out_res, 64'd3);
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
